// File: rtl/mem_pkg.sv
// C2 memory-bus encodings and line geometry, shared by mem_responder and the
// cache's memory-side driver so both ends agree on a single definition.
package mem_pkg;

  localparam int ADDR_W      = 15;  // line address (tag+set); storage is 1<<ADDR_W lines
  localparam int LINE_BYTES  = 16;
  localparam int BUS_BYTES   = 2;
  localparam int MEM_LATENCY = 100; // command cycle to first response cycle; keep >= BEATS+2

  localparam int BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BUS_W  = BUS_BYTES * 8;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RECV = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_ACK  = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_beat_buffer.sv
// One-line staging buffer: assembles incoming write beats and serialises a
// loaded line onto the bus, with a wrapping beat counter.
module mem_beat_buffer
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,        // store wr_data_i at the current beat, advance
  input  logic              adv_i,       // advance without storing
  input  logic              load_i,      // replace the whole line with line_i
  input  logic [BUS_W-1:0]  wr_data_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,      // line including this cycle's write beat
  output logic [BUS_W-1:0]  beat_data_o,
  output logic              last_o
);

  localparam int IDX_W = $clog2(BEATS);

  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]  beat_q, beat_d;

  assign last_o      = (beat_q == IDX_W'(BEATS - 1));
  assign beat_data_o = line_q[beat_q*BUS_W +: BUS_W];
  assign line_o      = line_d;

  // NOTE: defaults come first so every path assigns line_d/beat_d and no latch is inferred.
  always_comb begin
    line_d = line_q;
    beat_d = beat_q;
    if (load_i) line_d = line_i;
    if (wr_i)   line_d[beat_q*BUS_W +: BUS_W] = wr_data_i;
    if (wr_i || adv_i) beat_d = last_o ? '0 : beat_q + IDX_W'(1);
  end

  // NOTE: registers take <= so every flop updates from pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder on the C2 bus: fixed-latency line reads/writes over a
// shared tri-state bus. Define MEM_STATS_EN to add saturating read/write counters.
module mem_responder
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_mem_w,
  inout  wire  [BUS_W-1:0]  data_mem_w,
  inout  wire  [1:0]        cmd_mem_w,
  output logic              busy
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
`endif
);

  localparam int LAT_W = $clog2(MEM_LATENCY);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [LAT_W-1:0]  lat_q, lat_d, lat_dec;
  logic              owner_q, owner_d;
  logic [1:0]        cmd_in, cmd_out;
  logic [BUS_W-1:0]  data_out, buf_beat;
  logic              accept, accept_wr;
  logic              buf_wr, buf_adv, buf_load, buf_last, commit;
  logic [LINE_W-1:0] buf_line, rd_line_q;
  logic [LINE_W-1:0] mem_q [1 << ADDR_W];

  assign cmd_in    = cmd_mem_w;
  assign accept_wr = (cmd_in == C2_WRITE_LINE);
  assign accept    = (state_q == ST_IDLE) && (accept_wr || cmd_in == C2_READ_LINE);
  assign lat_dec   = lat_q - LAT_W'(1);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    buf_wr   = 1'b0;
    buf_adv  = 1'b0;
    buf_load = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        lat_d   = LAT_W'(MEM_LATENCY - 1);
        buf_wr  = accept_wr;               // beat 0 rides with the command
        state_d = accept_wr ? ST_RECV : ST_WAIT;
      end
      ST_RECV: begin
        lat_d  = lat_dec;
        buf_wr = 1'b1;
        if (buf_last) begin
          commit  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_dec;
        if (lat_dec == '0) begin
          buf_load = !wr_q;
          state_d  = wr_q ? ST_ACK : ST_SEND;
        end
      end
      ST_SEND: begin
        buf_adv = 1'b1;
        if (buf_last) state_d = ST_IDLE;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Take the bus one cycle after the cache's last driven cycle, keep it until release.
    owner_d = (state_d != ST_IDLE) &&
              (state_q == ST_WAIT || state_q == ST_SEND || state_q == ST_ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      lat_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      if (accept) begin
        addr_q <= addr_mem_w;
        wr_q   <= accept_wr;
      end
    end
  end

  // NOTE: storage has no reset; its contents must survive reset and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (commit) mem_q[addr_q] <= buf_line;
    rd_line_q <= mem_q[addr_q];
  end

  mem_beat_buffer u_beat_buffer (
    .clk        (clk),
    .rst_n      (reset),
    .wr_i       (buf_wr),
    .adv_i      (buf_adv),
    .load_i     (buf_load),
    .wr_data_i  (data_mem_w),
    .line_i     (rd_line_q),
    .line_o     (buf_line),
    .beat_data_o(buf_beat),
    .last_o     (buf_last)
  );

  assign cmd_out    = (state_q == ST_SEND || state_q == ST_ACK) ? C2_RESPONSE : C2_NOP;
  assign data_out   = (state_q == ST_SEND) ? buf_beat : '0;
  assign cmd_mem_w  = owner_q ? cmd_out  : 2'bzz;
  assign data_mem_w = owner_q ? data_out : {BUS_W{1'bz}};

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (accept) begin
      if (accept_wr) begin
        if (write_count != '1) write_count <= write_count + 32'd1;
      end else if (read_count != '1) begin
        read_count <= read_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized line traffic against a
// line-level memory model, timing derived from the bus rules.
module tb_mem_responder;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              tb_drive = 1'b0;
  logic [1:0]        tb_cmd = 2'd0;
  logic [BUS_W-1:0]  tb_data = '0;
  logic              busy;
  tri0  [1:0]        cmd_bus;   // released cmd reads as NOP
  tri1  [BUS_W-1:0]  data_bus;  // released data reads all-ones, unlike the responder's idle zeros

  int n_checks = 0;
  int n_fail   = 0;
  logic [LINE_W-1:0] model_mem [int];
  logic [ADDR_W-1:0] known_q [$];

`ifdef MEM_STATS_EN
  logic [31:0] read_count, write_count;
`endif

  assign cmd_bus  = tb_drive ? tb_cmd  : 2'bzz;
  assign data_bus = tb_drive ? tb_data : {BUS_W{1'bz}};

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .reset      (rst_n),
    .addr_mem_w (addr),
    .data_mem_w (data_bus),
    .cmd_mem_w  (cmd_bus),
    .busy       (busy)
`ifdef MEM_STATS_EN
    ,
    .read_count (read_count),
    .write_count(write_count)
`endif
  );

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction starting at a negedge; rel counts negedges after the
  // command cycle. Response window is [MEM_LATENCY, fin), released at fin.
  task automatic run_txn(input string tag, input bit is_wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] line, input int inj_rel,
                         input logic [1:0] inj_cmd, input int abort_rel);
    int fin, drive_end;
    logic [LINE_W-1:0] exp_line;
    logic [1:0]        exp_cmd;
    logic [BUS_W-1:0]  exp_data;
    bit                chk_data;
    fin       = MEM_LATENCY + (is_wr ? 1 : BEATS);
    drive_end = is_wr ? BEATS : 1;
    exp_line  = is_wr ? line : model_mem[int'(a)];
    tb_drive  = 1'b1;
    tb_cmd    = is_wr ? C2_WRITE_LINE : C2_READ_LINE;
    addr      = a;
    tb_data   = is_wr ? line[BUS_W-1:0] : BUS_W'($urandom);
    for (int rel = 1; rel <= fin; rel++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'(rel < fin)) begin
        n_fail++;
        $display("FAIL %s busy rel=%0d got %0b want %0b", tag, rel, busy, rel < fin);
      end
      if (rel > drive_end) begin
        chk_data = 1'b1;
        if (rel == fin) begin
          exp_cmd = C2_NOP; exp_data = '1;
        end else if (rel < MEM_LATENCY) begin
          exp_cmd = C2_NOP; exp_data = '0;
        end else begin
          exp_cmd  = C2_RESPONSE;
          chk_data = !is_wr;
          exp_data = exp_line[(rel-MEM_LATENCY)*BUS_W +: BUS_W];
        end
        n_checks++;
        if (cmd_bus !== exp_cmd) begin
          n_fail++;
          $display("FAIL %s cmd rel=%0d got %0h want %0h", tag, rel, cmd_bus, exp_cmd);
        end
        if (chk_data) begin
          n_checks++;
          if (data_bus !== exp_data) begin
            n_fail++;
            $display("FAIL %s data rel=%0d got %04h want %04h", tag, rel, data_bus, exp_data);
          end
        end
      end
      if (rel == drive_end) begin
        tb_drive = 1'b0;
      end else if (is_wr && rel < BEATS) begin
        tb_cmd  = (rel == inj_rel) ? inj_cmd : C2_NOP;
        tb_data = line[rel*BUS_W +: BUS_W];
        addr    = ADDR_W'($urandom);
      end
      if (rel == abort_rel) begin
        tb_drive = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s abort_busy got %0b want 0", tag, busy);
        end
        if (data_bus !== '1 || cmd_bus !== 2'd0) begin
          n_fail++;
          $display("FAIL %s abort_release got cmd %0h data %04h want released", tag, cmd_bus, data_bus);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (is_wr) model_mem[int'(a)] = line;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        run_txn("preload", 1'b1, a, rand_line(), 0, C2_NOP, 0);
        known_q.push_back(a);
      end
      tb_drive = 1'b0;
      rst_n    = 1'b0;
      repeat (5) begin
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cmd_bus !== 2'd0 || data_bus !== '1) begin
          n_fail++;
          $display("FAIL reset_idle got busy %0b cmd %0h data %04h want 0/released", busy, cmd_bus, data_bus);
        end
      end
      rst_n = 1'b1;
    end
    run_txn("read_after_reset", 1'b0, a, '0, 0, C2_NOP, 0);
  endtask

  task automatic test_write_ack();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BUS_W +: BUS_W] = 16'h1100 + 16'(k);
    run_txn("write_0123", 1'b1, 15'h0123, l, 0, C2_NOP, 0);
    known_q.push_back(15'h0123);
  endtask

  task automatic test_read_response();
    n_checks++;
    if (model_mem[32'h0123][BUS_W-1:0] !== 16'h1100 || model_mem[32'h0123][LINE_W-1 -: BUS_W] !== 16'h1107) begin
      n_fail++;
      $display("FAIL model_0123 got %032h want beats 1100..1107", model_mem[32'h0123]);
    end
    run_txn("read_0123", 1'b0, 15'h0123, '0, 0, C2_NOP, 0);
  endtask

  task automatic test_busy_ignore();
    logic [ADDR_W-1:0] a, b;
    a = ADDR_W'($urandom);
    b = a ^ 15'h5555;
    run_txn("write_inj_read", 1'b1, a, rand_line(), 3, C2_READ_LINE, 0);
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || cmd_bus !== 2'd0 || data_bus !== '1) begin
        n_fail++;
        $display("FAIL ignore_idle got busy %0b cmd %0h data %04h want idle", busy, cmd_bus, data_bus);
      end
    end
    run_txn("write_inj_write", 1'b1, b, rand_line(), 6, C2_WRITE_LINE, 0);
    run_txn("read_inj_a", 1'b0, a, '0, 0, C2_NOP, 0);
    run_txn("read_inj_b", 1'b0, b, '0, 0, C2_NOP, 0);
    known_q.push_back(a);
    known_q.push_back(b);
  endtask

  task automatic test_reset_mid_write();
    run_txn("preload_7fff", 1'b1, 15'h7FFF, rand_line(), 0, C2_NOP, 0);
    run_txn("abort_write_7fff", 1'b1, 15'h7FFF, rand_line(), 0, C2_NOP, 4);
    run_txn("read_7fff_old", 1'b0, 15'h7FFF, '0, 0, C2_NOP, 0);
    known_q.push_back(15'h7FFF);
  endtask

  task automatic test_reset_mid_read();
    run_txn("abort_read_0123", 1'b0, 15'h0123, '0, 0, C2_NOP, MEM_LATENCY + 3);
    run_txn("reread_0123", 1'b0, 15'h0123, '0, 0, C2_NOP, 0);
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    bit is_wr;
    for (int i = 0; i < 8; i++) begin
      is_wr = ($urandom_range(0, 1) == 1);
      if (is_wr) begin
        a = ($urandom_range(0, 2) == 0) ? known_q[$urandom_range(0, known_q.size() - 1)]
                                        : ADDR_W'($urandom);
        run_txn("b2b_write", 1'b1, a, rand_line(), 0, C2_NOP, 0);
        known_q.push_back(a);
      end else begin
        a = known_q[$urandom_range(0, known_q.size() - 1)];
        run_txn("b2b_read", 1'b0, a, '0, 0, C2_NOP, 0);
      end
    end
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (read_count !== 32'd0 || write_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset got %0d/%0d want 0/0", read_count, write_count);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      run_txn("stats_read", 1'b0, known_q[i], '0, 0, C2_NOP, 0);
    for (int i = 0; i < 2; i++)
      run_txn("stats_write", 1'b1, known_q[i], rand_line(), 0, C2_NOP, 0);
    n_checks++;
    if (read_count !== 32'd3 || write_count !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_count got %0d/%0d want 3/2", read_count, write_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (read_count !== 32'd0 || write_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_clear got %0d/%0d want 0/0", read_count, write_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_ack();
    test_read_response();
    test_busy_ignore();
    test_reset_mid_write();
    test_reset_mid_read();
    test_back_to_back();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
